// File: rtl/bldc_commutator.sv
// bldc_commutator: six-step hall commutation with hall filtering, per-phase dead time, fault latch and stall detect
module bldc_commutator #(
  parameter int DEADTIME_CYCLES = 16,
  parameter int HALL_FILTER_CYCLES = 64,
  parameter int STALL_CYCLES = 3_200_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ena,
  input  logic       pwm_in,
  input  logic       dir,
  input  logic [2:0] hall,
  input  logic       fault_n,
  input  logic       clear_fault,
  output logic [2:0] inh,
  output logic [2:0] inl,
  output logic [2:0] hall_state,
  output logic       hall_error,
  output logic       fault_latched,
  output logic       stall
);
  localparam int DW = $clog2(DEADTIME_CYCLES + 1);
  localparam int HW = $clog2(HALL_FILTER_CYCLES + 1);
  localparam int SW = $clog2(STALL_CYCLES + 1);
  logic [2:0] hall_s1, hall_s2, hall_cand, hp, lp, req_h, req_l, sat_h, sat_l;
  logic [2:0][DW-1:0] dh, dl;
  logic [HW-1:0] hcnt;
  logic [SW-1:0] scnt;
  logic flt_s1, flt_s2, active, accept;
  always_comb begin
    hp = '0;
    lp = '0;
    case (hall_state)
      3'b101: begin hp = 3'b001; lp = 3'b010; end
      3'b100: begin hp = 3'b001; lp = 3'b100; end
      3'b110: begin hp = 3'b010; lp = 3'b100; end
      3'b010: begin hp = 3'b010; lp = 3'b001; end
      3'b011: begin hp = 3'b100; lp = 3'b001; end
      3'b001: begin hp = 3'b100; lp = 3'b010; end
      default: begin hp = '0; lp = '0; end
    endcase
    hall_error = hall_state == 3'b000 || hall_state == 3'b111;
    accept = hall_s2 != hall_state && hall_s2 == hall_cand && hcnt == HW'(HALL_FILTER_CYCLES - 1);
    // the raw synchronised fault gates immediately; the latch keeps it off afterwards
    active = ena & ~hall_error & ~fault_latched & flt_s2;
    req_h = active ? (dir ? lp : hp) & {3{pwm_in}} : '0;
    req_l = active ? (dir ? hp : lp) : '0;
    for (int i = 0; i < 3; i++) begin
      sat_h[i] = dh[i] == DW'(DEADTIME_CYCLES);
      sat_l[i] = dl[i] == DW'(DEADTIME_CYCLES);
    end
    stall = scnt == SW'(STALL_CYCLES);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hall_s1 <= '0;
      hall_s2 <= '0;
      hall_cand <= '0;
      hall_state <= '0;
      hcnt <= '0;
      flt_s1 <= 1'b1;
      flt_s2 <= 1'b1;
      fault_latched <= 1'b0;
      scnt <= '0;
      inh <= '0;
      inl <= '0;
      dh <= '0;
      dl <= '0;
    end else begin
      hall_s1 <= hall;
      hall_s2 <= hall_s1;
      hall_cand <= hall_s2;
      hcnt <= hall_s2 == hall_state ? '0 : hall_s2 != hall_cand ? HW'(1) : hcnt + 1'b1;
      if (accept) hall_state <= hall_s2;
      flt_s1 <= fault_n;
      flt_s2 <= flt_s1;
      fault_latched <= ~flt_s2 | (fault_latched & ~clear_fault);
      scnt <= (!ena || accept) ? '0 : stall ? scnt : scnt + 1'b1;
      inh <= req_h & sat_h;
      inl <= req_l & sat_l;
      // dh tracks how long inl has been off (gates inh), dl the reverse
      for (int i = 0; i < 3; i++) begin
        dh[i] <= inl[i] ? '0 : sat_h[i] ? dh[i] : dh[i] + 1'b1;
        dl[i] <= inh[i] ? '0 : sat_l[i] ? dl[i] : dl[i] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bldc_commutator.sv
// tb_bldc_commutator: table-driven commutation vectors plus hand sequences for filter, dead time, fault and stall
module tb_bldc_commutator;
  logic clk = 0, reset_n = 0, ena = 1, pwm_in = 1, dir = 0, fault_n = 1, clear_fault = 0;
  logic [2:0] hall = 3'b101;
  logic [2:0] inh, inl, hall_state;
  logic hall_error, fault_latched, stall;
  int total = 0, passed = 0;

  bldc_commutator #(.DEADTIME_CYCLES(16), .HALL_FILTER_CYCLES(64), .STALL_CYCLES(1000)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .pwm_in(pwm_in), .dir(dir), .hall(hall),
    .fault_n(fault_n), .clear_fault(clear_fault), .inh(inh), .inl(inl),
    .hall_state(hall_state), .hall_error(hall_error), .fault_latched(fault_latched), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] hall;
    logic dir, pwm, en;
    logic [2:0] eh, el;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) if (reset_n) begin
    total++;
    if ((inh & inl) == 3'b000) passed++;
    else $display("FAIL overlap: inh %b inl %b at %0t", inh, inl, $time);
  end

  initial begin
    int tf, tr;
    tbl[0]  = '{3'b100, 0, 1, 1, 3'b001, 3'b100};
    tbl[1]  = '{3'b110, 0, 1, 1, 3'b010, 3'b100};
    tbl[2]  = '{3'b010, 0, 1, 1, 3'b010, 3'b001};
    tbl[3]  = '{3'b011, 0, 1, 1, 3'b100, 3'b001};
    tbl[4]  = '{3'b001, 0, 1, 1, 3'b100, 3'b010};
    tbl[5]  = '{3'b101, 0, 1, 1, 3'b001, 3'b010};
    tbl[6]  = '{3'b101, 1, 1, 1, 3'b010, 3'b001};
    tbl[7]  = '{3'b011, 1, 1, 1, 3'b001, 3'b100};
    tbl[8]  = '{3'b110, 1, 1, 1, 3'b100, 3'b010};
    tbl[9]  = '{3'b110, 0, 0, 1, 3'b000, 3'b100};
    tbl[10] = '{3'b110, 0, 1, 0, 3'b000, 3'b000};
    tbl[11] = '{3'b110, 0, 1, 1, 3'b010, 3'b100};

    cyc(2);
    chk("rst_inh", 8'(inh), 8'h0);
    chk("rst_inl", 8'(inl), 8'h0);
    chk("rst_hall_state", 8'(hall_state), 8'h0);
    chk("rst_hall_error", 8'(hall_error), 8'h1);
    chk("rst_fault", 8'(fault_latched), 8'h0);
    chk("rst_stall", 8'(stall), 8'h0);
    reset_n = 1;
    cyc(65);
    chk("accept_not_yet", 8'(hall_state), 8'h0);
    cyc(1);
    chk("accept_66", 8'(hall_state), 8'b101);
    chk("gates_not_yet", 8'(inh | inl), 8'h0);
    cyc(1);
    chk("first_inh", 8'(inh), 8'b001);
    chk("first_inl", 8'(inl), 8'b010);
    chk("first_err", 8'(hall_error), 8'h0);

    for (int i = 0; i < 12; i++) begin
      hall = tbl[i].hall; dir = tbl[i].dir; pwm_in = tbl[i].pwm; ena = tbl[i].en;
      cyc(200);
      chk($sformatf("tbl%0d_state", i), 8'(hall_state), 8'(tbl[i].hall));
      chk($sformatf("tbl%0d_inh", i), 8'(inh), 8'(tbl[i].eh));
      chk($sformatf("tbl%0d_inl", i), 8'(inl), 8'(tbl[i].el));
    end

    // phase A reversal A+ -> A- by direction flip
    hall = 3'b101; dir = 0; pwm_in = 1; ena = 1;
    cyc(200);
    chk("rev_pre_inh", 8'(inh), 8'b001);
    dir = 1; tf = -1; tr = -1;
    for (int j = 1; j <= 40; j++) begin
      cyc(1);
      if (!inh[0] && tf < 0) tf = j;
      if (inl[0] && tr < 0) tr = j;
    end
    chk("rev_inh_fall", 8'(tf), 8'd1);
    chk("rev_gap_min", 8'(tr - tf >= 16 && tr - tf <= 17), 8'h1);
    dir = 0;
    cyc(200);

    hall = 3'b100; cyc(1); hall = 3'b101; cyc(100);
    chk("glitch1_state", 8'(hall_state), 8'b101);
    chk("glitch1_inh", 8'(inh), 8'b001);
    hall = 3'b100; cyc(63); hall = 3'b101; cyc(100);
    chk("glitch63_state", 8'(hall_state), 8'b101);
    chk("glitch63_inl", 8'(inl), 8'b010);
    hall = 3'b100; cyc(64); hall = 3'b101; cyc(2);
    chk("pulse64_state", 8'(hall_state), 8'b100);
    cyc(100);
    chk("pulse64_back", 8'(hall_state), 8'b101);

    hall = 3'b111; cyc(66);
    chk("err111_flag", 8'(hall_error), 8'h1);
    cyc(1);
    chk("err111_gates", 8'({inh, inl}), 8'h0);
    hall = 3'b001; cyc(200);
    chk("err_recover_inh", 8'(inh), 8'b100);
    chk("err_recover_inl", 8'(inl), 8'b010);

    fault_n = 0; cyc(2);
    clear_fault = 1; cyc(1); clear_fault = 0;
    chk("fault_latch", 8'(fault_latched), 8'h1);
    chk("fault_gates", 8'({inh, inl}), 8'h0);
    fault_n = 1; cyc(4);
    chk("fault_sticky", 8'(fault_latched), 8'h1);
    clear_fault = 1; cyc(1); clear_fault = 0;
    chk("fault_clear", 8'(fault_latched), 8'h0);
    cyc(1);
    chk("fault_resume_inh", 8'(inh), 8'b100);
    chk("fault_resume_inl", 8'(inl), 8'b010);

    ena = 0; cyc(1);
    chk("stall_ena0", 8'(stall), 8'h0);
    ena = 1; cyc(999);
    chk("stall_999", 8'(stall), 8'h0);
    cyc(1);
    chk("stall_1000", 8'(stall), 8'h1);
    hall = 3'b101; cyc(70);
    chk("stall_hall_clr", 8'(stall), 8'h0);
    cyc(1000);
    chk("stall_again", 8'(stall), 8'h1);
    ena = 0; cyc(1);
    chk("stall_ena_clr", 8'(stall), 8'h0);

    ena = 1; cyc(20);
    #2 reset_n = 0;
    #1 chk("async_rst_gates", 8'({inh, inl}), 8'h0);
    chk("async_rst_state", 8'(hall_state), 8'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
